// File: rtl/mat_mult_seq_if.sv
// Element stream in (A then B, row-major) and C result stream out for mat_mult_seq.
// The master side is the loader/consumer; the slave side is the multiplier.
interface mat_mult_seq_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 32,
  parameter int unsigned IW = 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [IW-1:0]        out_row;
  logic [IW-1:0]        out_col;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col
  );
endinterface

// File: rtl/mat_mult_seq.sv
// Square matrix multiplier C = A x B on a single shared signed MAC.
// Loads A then B from one stream, computes each C[i][j] over N cycles, emits row-major.
module mat_mult_seq #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 32,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  mat_mult_seq_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StLoad, StMac, StEmit} state_e;

  localparam logic [IW-1:0] Last = IW'(N - 1);

  state_e               state;
  logic signed [DW-1:0] a_mem [N][N];
  logic signed [DW-1:0] b_mem [N][N];
  logic                 ld_sel;
  logic [IW-1:0]        ld_r, ld_c;
  logic [IW-1:0]        i, j, k;
  logic signed [OW-1:0] acc;
  logic signed [OW-1:0] acc_sum;
  logic signed [2*DW-1:0] prod;
  logic signed [OW-1:0] out_data_q;
  logic [IW-1:0]        out_row_q, out_col_q;
  logic                 done_q;

  // Operands widened first so the product keeps its full signed 2*DW range.
  assign prod    = (2*DW)'(a_mem[i][k]) * (2*DW)'(b_mem[k][j]);
  assign acc_sum = acc + OW'(prod);

  assign busy          = (state != StIdle);
  assign done          = done_q;
  assign bus.in_ready  = (state == StLoad);
  assign bus.out_valid = (state == StEmit);
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;

  // Operand storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!reset && state == StLoad && bus.in_valid) begin
      if (!ld_sel) a_mem[ld_r][ld_c] <= bus.in_data;
      else         b_mem[ld_r][ld_c] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      ld_sel     <= 1'b0;
      ld_r       <= '0;
      ld_c       <= '0;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      acc        <= '0;
      out_data_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            state  <= StLoad;
            ld_sel <= 1'b0;
            ld_r   <= '0;
            ld_c   <= '0;
          end
        end
        StLoad: begin
          if (bus.in_valid) begin
            if (ld_c == Last) begin
              ld_c <= '0;
              if (ld_r == Last) begin
                ld_r <= '0;
                if (ld_sel) begin
                  state <= StMac;
                  i     <= '0;
                  j     <= '0;
                  k     <= '0;
                  acc   <= '0;
                end else begin
                  ld_sel <= 1'b1;
                end
              end else begin
                ld_r <= ld_r + IW'(1);
              end
            end else begin
              ld_c <= ld_c + IW'(1);
            end
          end
        end
        StMac: begin
          acc <= acc_sum;
          if (k == Last) begin
            state      <= StEmit;
            k          <= '0;
            out_data_q <= acc_sum;
            out_row_q  <= i;
            out_col_q  <= j;
          end else begin
            k <= k + IW'(1);
          end
        end
        StEmit: begin
          if (bus.out_ready) begin
            if (i == Last && j == Last) begin
              state  <= StIdle;
              done_q <= 1'b1;
            end else begin
              state <= StMac;
              acc   <= '0;
              if (j == Last) begin
                j <= '0;
                i <= i + IW'(1);
              end else begin
                j <= j + IW'(1);
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed bench for mat_mult_seq (N=2): a 32-bit and a 16-bit output instance run in lockstep.
module tb_mat_mult_seq;
  localparam int unsigned N  = 2;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [3:0][31:0] c;
    logic             gaps;
    logic             bp;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start;
  logic busy0, done0, busy1, done1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  vec_t tv [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mat_mult_seq_if #(.DW(DW), .OW(32), .IW(1)) bus0 ();
  mat_mult_seq_if #(.DW(DW), .OW(16), .IW(1)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_data   = bus0.in_data;
  assign bus1.out_ready = bus0.out_ready;

  mat_mult_seq #(.N(N), .DW(DW), .OW(32)) dut0 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy0),
    .done  (done0),
    .bus   (bus0.slave)
  );

  mat_mult_seq #(.N(N), .DW(DW), .OW(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy1),
    .done  (done1),
    .bus   (bus1.slave)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3,
                              input int c0, c1, c2, c3, input bit g, input bit p);
    mk.a[0] = a0; mk.a[1] = a1; mk.a[2] = a2; mk.a[3] = a3;
    mk.b[0] = b0; mk.b[1] = b1; mk.b[2] = b2; mk.b[3] = b3;
    mk.c[0] = c0; mk.c[1] = c1; mk.c[2] = c2; mk.c[3] = c3;
    mk.gaps = g;
    mk.bp   = p;
  endfunction

  // Called at a negedge with the DUT idle. abort > 0 resets after that many results.
  task automatic run(input vec_t v, input int abort);
    int               c0, got, stall, w;
    bit               timing;
    logic signed [15:0] e16;
    timing         = !v.gaps && !v.bp;
    bus0.out_ready = v.gaps;
    start          = 1'b1;
    c0             = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < 2 * N * N; e++) begin
      if (v.gaps && (e % 2 == 1)) begin
        bus0.in_valid = 1'b0;
        bus0.in_data  = 8'sh55;
        repeat (2) @(negedge clk);
      end
      if (e == 0) chk("in_ready in load", bus0.in_ready, 1);
      bus0.in_valid = 1'b1;
      bus0.in_data  = (e < 4) ? v.a[e][7:0] : v.b[e-4][7:0];
      start         = v.gaps && (e == 3);
      @(negedge clk);
    end
    start         = 1'b0;
    bus0.in_valid = v.gaps;
    bus0.in_data  = 8'sh7f;
    got = 0; stall = 0; w = 0;
    while (got < 4 && w < 200) begin
      w++;
      if (got == abort && abort > 0) begin
        chk("busy before reset", busy0, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("busy after reset", busy0, 0);
        chk("out_valid after reset", bus0.out_valid, 0);
        chk("out_data after reset", bus0.out_data, 0);
        chk("out_row after reset", bus0.out_row, 0);
        repeat (4) begin
          @(negedge clk);
          chk("no done after reset", done0, 0);
        end
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b0;
        return;
      end
      if (v.bp && got == 0 && bus0.out_valid && stall < 3) begin
        bus0.out_ready = 1'b0;
        stall++;
        chk("stall out_data", bus0.out_data, longint'($signed(v.c[0])));
        chk("stall out_row", bus0.out_row, 0);
        chk("stall out_col", bus0.out_col, 0);
      end else begin
        bus0.out_ready = 1'b1;
      end
      if (done0) chk("early done", done0, 0);
      if (bus0.out_valid && bus0.out_ready) begin
        e16 = v.c[got][15:0];
        chk("out_data", bus0.out_data, longint'($signed(v.c[got])));
        chk("out_data16", bus1.out_data, e16);
        chk("out_row", bus0.out_row, got / 2);
        chk("out_col", bus0.out_col, got % 2);
        if (timing) chk("handshake cycle", cyc - c0, 11 + 3 * got);
        got++;
      end
      @(negedge clk);
    end
    if (got < 4) chk("result count", got, 4);
    chk("done pulse", done0, 1);
    chk("busy at done", busy0, 0);
    if (timing) chk("done cycle", cyc - c0, 21);
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b0;
    @(negedge clk);
    chk("done width", done0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 0);
    tv[1] = mk(-1, 2, 3, -4, 5, -6, -7, 8, -19, 22, 43, -50, 0, 0);
    tv[2] = mk(1, 0, 0, 1, 9, -3, 127, -128, 9, -3, 127, -128, 0, 0);
    tv[3] = mk(-128, -128, 0, 0, -128, 0, -128, 0, 32768, 0, 0, 0, 0, 0);
    tv[4] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 1, 0);
    tv[5] = mk(-1, 2, 3, -4, 5, -6, -7, 8, -19, 22, 43, -50, 0, 1);

    reset          = 1'b1;
    start          = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_data   = '0;
    bus0.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset in_ready", bus0.in_ready, 0);
    chk("reset out_valid", bus0.out_valid, 0);
    chk("reset out_data", bus0.out_data, 0);
    chk("reset out_row", bus0.out_row, 0);
    chk("reset out_col", bus0.out_col, 0);

    // Stray input traffic while idle must not start anything.
    bus0.in_valid = 1'b1;
    bus0.in_data  = 8'sh33;
    repeat (3) @(negedge clk);
    chk("idle in_valid busy", busy0, 0);
    chk("idle in_valid in_ready", bus0.in_ready, 0);
    bus0.in_valid = 1'b0;

    for (int t = 0; t < 6; t++) run(tv[t], 0);

    // Reset during the MAC of C[1][0], then a fresh run must be clean.
    run(tv[0], 2);
    run(tv[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
